// File: rtl/mips_pkg.sv
// Shared widths and the responder state encoding for the data-memory port.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word array with per-byte write enables and a registered read.
module dmem_ram
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BYTES-1:0]  be,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BYTES; i++) begin
          if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[waddr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with req/ack handshake, programmable wait states and
// alignment/range error reporting in front of a byte-enabled word array.
//
//   state | meaning
//   IDLE  | waiting for req; accepts and latches the request
//   WAIT  | counting down wait states before the memory access
//   RESP  | ack high for one cycle, err/rdata valid
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BYTES-1:0]  be,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be within 0..15");
  end

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ack_q, busy_q, rd_sel_q;
  logic              we_q;
  logic [AW-1:0]     widx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTES-1:0]  be_q;

  logic              req_bad, accept, access;
  logic              mem_we;
  logic [AW-1:0]     mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [BYTES-1:0]  mem_be;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    req_bad = (addr[1:0] != 2'b00) ||
              ({2'b00, addr[ADDR_W-1:2]} >= 32'(DEPTH_WORDS));
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (req_bad) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = RESP;
            err_d   = 1'b0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
            err_d   = 1'b0;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // Zero-wait builds access on the accept edge, before the latches are loaded.
  always_comb begin
    if (state_q == IDLE) begin
      mem_we    = we;
      mem_idx   = addr[AW+1:2];
      mem_wdata = wdata;
      mem_be    = be;
    end else begin
      mem_we    = we_q;
      mem_idx   = widx_q;
      mem_wdata = wdata_q;
      mem_be    = be_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rd_sel_q <= 1'b0;
      we_q     <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ack_q    <= (state_d == RESP);
      busy_q   <= (state_d != IDLE);
      rd_sel_q <= access & ~mem_we;
      if (accept) begin
        we_q    <= we;
        widx_q  <= addr[AW+1:2];
        wdata_q <= wdata;
        be_q    <= be;
      end
    end
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (access & ~rst),
    .we    (mem_we),
    .be    (mem_be),
    .waddr (mem_idx),
    .wdata (mem_wdata),
    .rdata (ram_rdata)
  );

  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign rdata = rd_sel_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance and a zero-wait instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        ack, err, busy;

  logic        req_z, we_z;
  logic [31:0] addr_z, wdata_z, rdata_z;
  logic [3:0]  be_z;
  logic        ack_z, err_z, busy_z;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack), .err(err), .rdata(rdata), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_z (
    .clk(clk), .rst(rst), .req(req_z), .we(we_z), .addr(addr_z), .wdata(wdata_z),
    .be(be_z), .ack(ack_z), .err(err_z), .rdata(rdata_z), .busy(busy_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one transaction on the 2-wait instance; starts and ends #1 after an edge.
  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rd, input bit drop_early);
    int lat;
    lat   = 0;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    @(posedge clk); #1;
    if (drop_early) begin
      req   = 1'b0;
      we    = ~w;
      addr  = 32'h0000_0ffc;
      wdata = 32'h0;
      be    = 4'h0;
    end
    check({tag, " busy"}, {31'b0, busy}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      if (ack) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, " rdata"}, rdata, exp_rd);
    @(posedge clk); #1;
    check({tag, " ack pulse"}, {31'b0, ack}, 32'd0);
    check({tag, " busy drop"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h1234_5678; be = 4'hf;
    req_z = 1'b0; we_z = 1'b0; addr_z = 32'h0; wdata_z = 32'h0; be_z = 4'h0;

    // Reset held with req high: nothing accepted
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst ack", {31'b0, ack}, 32'd0);
      check("rst err", {31'b0, err}, 32'd0);
      check("rst rdata", rdata, 32'd0);
      check("rst busy", {31'b0, busy}, 32'd0);
    end
    req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post rst busy", {31'b0, busy}, 32'd0);
    check("post rst ack", {31'b0, ack}, 32'd0);

    xact("st 0x10",  1'b1, 32'h10, 32'hDEAD_BEEF, 4'hf, 3, 1'b0, 32'h0,         1'b0);
    xact("ld 0x10",  1'b0, 32'h10, 32'h0,         4'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
    xact("st be5",   1'b1, 32'h10, 32'h1122_3344, 4'h5, 3, 1'b0, 32'h0,         1'b0);
    xact("ld be5",   1'b0, 32'h10, 32'h0,         4'hf, 3, 1'b0, 32'hDE22_BE44, 1'b0);
    xact("st be0",   1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 3, 1'b0, 32'h0,         1'b0);
    xact("ld be0",   1'b0, 32'h10, 32'h0,         4'h0, 3, 1'b0, 32'hDE22_BE44, 1'b0);
    xact("ld drop",  1'b0, 32'h10, 32'h0,         4'h0, 3, 1'b0, 32'hDE22_BE44, 1'b1);

    xact("st w0",    1'b1, 32'h0,  32'h0102_0304, 4'hf, 3, 1'b0, 32'h0,         1'b0);
    xact("ld 0x12",  1'b0, 32'h12, 32'h0,         4'hf, 1, 1'b1, 32'h0,         1'b0);
    xact("st 0x1000",1'b1, 32'h1000, 32'hBAD0_BAD0, 4'hf, 1, 1'b1, 32'h0,       1'b0);
    xact("ld w0",    1'b0, 32'h0,  32'h0,         4'h0, 3, 1'b0, 32'h0102_0304, 1'b0);
    xact("st last",  1'b1, 32'hFFC, 32'hA5A5_5A5A, 4'hf, 3, 1'b0, 32'h0,        1'b0);
    xact("ld last",  1'b0, 32'hFFC, 32'h0,        4'h0, 3, 1'b0, 32'hA5A5_5A5A, 1'b0);

    // Reset during WAIT abandons the store
    xact("st 0x20",  1'b1, 32'h20, 32'h1111_1111, 4'hf, 3, 1'b0, 32'h0,         1'b0);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D; be = 4'hf;
    @(posedge clk); #1;
    rst = 1'b1;
    req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst mid ack", {31'b0, ack}, 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("after abort ack", {31'b0, ack}, 32'd0);
    end
    xact("ld 0x20",  1'b0, 32'h20, 32'h0,         4'h0, 3, 1'b0, 32'h1111_1111, 1'b0);

    // Zero-wait instance: seed two words, then back-to-back loads with req held
    req_z = 1'b1; we_z = 1'b1; addr_z = 32'h0; wdata_z = 32'h0000_0055; be_z = 4'hf;
    @(posedge clk); #1;
    check("z st0 ack", {31'b0, ack_z}, 32'd1);
    addr_z = 32'h4; wdata_z = 32'h0000_0066;
    @(posedge clk); #1;
    check("z gap ack", {31'b0, ack_z}, 32'd0);
    @(posedge clk); #1;
    check("z st1 ack", {31'b0, ack_z}, 32'd1);
    req_z = 1'b0;
    @(posedge clk); #1;

    req_z = 1'b1; we_z = 1'b0; addr_z = 32'h0;
    @(posedge clk); #1;
    check("z ld0 ack", {31'b0, ack_z}, 32'd1);
    check("z ld0 rdata", rdata_z, 32'h0000_0055);
    check("z ld0 err", {31'b0, err_z}, 32'd0);
    addr_z = 32'h4;
    @(posedge clk); #1;
    check("z ld pulse", {31'b0, ack_z}, 32'd0);
    @(posedge clk); #1;
    check("z ld1 ack", {31'b0, ack_z}, 32'd1);
    check("z ld1 rdata", rdata_z, 32'h0000_0066);
    req_z = 1'b0;
    @(posedge clk); #1;
    check("z ld1 pulse", {31'b0, ack_z}, 32'd0);
    check("z busy", {31'b0, busy_z}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
